// File: rtl/fetch_aligner_if.sv
// Handshake bundle between fetch_aligner, the instruction memory port and the decompressor.
// Latency: none, wires only.
// Backpressure: carries fetch_gnt_i (memory side) and instr_ready_i (consumer side) back to the aligner.
//
// Signal groups:
//   fetch_*  : word-aligned request/grant plus in-order response (rvalid/rdata)
//   instr_*  : one realigned raw instruction per valid/ready handshake, with its PC
//   branch_* : redirect strobe and target
// master = the aligner; slave = the memory/consumer/redirect side.
interface fetch_aligner_if;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_gnt_i;
  logic        fetch_rvalid_i;
  logic [31:0] fetch_rdata_i;

  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;

  logic        branch_i;
  logic [31:0] branch_addr_i;

  modport master (
    output fetch_req_o,
    output fetch_addr_o,
    input  fetch_gnt_i,
    input  fetch_rvalid_i,
    input  fetch_rdata_i,
    output instr_valid_o,
    input  instr_ready_i,
    output instr_o,
    output instr_pc_o,
    output instr_compressed_o,
    input  branch_i,
    input  branch_addr_i
  );

  modport slave (
    input  fetch_req_o,
    input  fetch_addr_o,
    output fetch_gnt_i,
    output fetch_rvalid_i,
    output fetch_rdata_i,
    input  instr_valid_o,
    output instr_ready_i,
    input  instr_o,
    input  instr_pc_o,
    input  instr_compressed_o,
    output branch_i,
    output branch_addr_i
  );
endinterface

// File: rtl/fetch_aligner.sv
// Instruction-fetch aligner: word fetches in, one realigned 16/32-bit raw instruction (+PC) out.
// Latency: a response word becomes visible as an instruction the cycle after fetch_rvalid_i (no bypass).
// Backpressure: holds the instruction while instr_ready_i is low; stops requesting once 2+ halfwords wait.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : fetch_aligner_if.master (fetch request/response, instruction output, redirect)
// Parameter RESET_PC : PC of the first instruction after reset (bit 0 ignored).
// Optional feature macro FETCH_ALIGN_COMPRESSED_EN: when defined, 16-bit instructions and
// halfword-aligned targets are supported; when undefined, only word-aligned 32-bit instructions.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  fetch_aligner_if.master bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,  // no request outstanding
    ST_WAIT  = 2'd1,  // one request outstanding, data kept
    ST_FLUSH = 2'd2   // one request outstanding, data dropped (made stale by a redirect)
  } state_e;

`ifdef FETCH_ALIGN_COMPRESSED_EN
  localparam logic [31:0] PC_RESET = {RESET_PC[31:1], 1'b0};
`else
  localparam logic [31:0] PC_RESET = {RESET_PC[31:2], 2'b00};
`endif
  localparam logic [31:0] FA_RESET = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [15:0] hw_q [3];
  logic [15:0] hw_d [3];
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fa_q, fa_d;
`ifdef FETCH_ALIGN_COMPRESSED_EN
  // Set by a redirect to an upper-halfword target: the first kept word only contributes hw 1.
  logic        skip_q, skip_d;
`endif

  logic        is_comp;
  logic        valid;
  logic        consume;
  logic [1:0]  cnt_left;
  logic        req;
  logic        grant;
  logic        keep;
  logic [15:0] rd_lo, rd_hi;

  assign rd_lo = bus.fetch_rdata_i[15:0];
  assign rd_hi = bus.fetch_rdata_i[31:16];

`ifdef FETCH_ALIGN_COMPRESSED_EN
  assign is_comp = (hw_q[0][1:0] != 2'b11);
  assign valid   = ((cnt_q >= 2'd1) && is_comp) || (cnt_q >= 2'd2);
`else
  assign is_comp = 1'b0;
  assign valid   = (cnt_q >= 2'd2);
`endif

  assign consume  = valid && bus.instr_ready_i;
  assign cnt_left = consume ? (cnt_q - (is_comp ? 2'd1 : 2'd2)) : cnt_q;

  // Requesting only when at most one halfword remains after this cycle's consumption keeps
  // the buffer within its three slots once the word lands. Gated by rst_ni so nothing is
  // requested while reset is asserted and the first request appears as soon as it releases.
  assign req   = rst_ni && (state_q == ST_RUN) && (cnt_left <= 2'd1) && !bus.branch_i;
  assign grant = req && bus.fetch_gnt_i;

  // A response in the redirect cycle belongs to the old path and is dropped.
  assign keep  = (state_q == ST_WAIT) && bus.fetch_rvalid_i && !bus.branch_i;

  assign bus.fetch_req_o   = req;
  assign bus.fetch_addr_o  = fa_q;
  assign bus.instr_valid_o = valid;
  assign bus.instr_pc_o    = pc_q;
  assign bus.instr_o       = !valid  ? 32'h0000_0000 :
                             is_comp ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
`ifdef FETCH_ALIGN_COMPRESSED_EN
  assign bus.instr_compressed_o = valid && is_comp;
`else
  assign bus.instr_compressed_o = 1'b0;
`endif

  // Target bits below the fetch granule are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.branch_addr_i[1:0];

  // Outstanding-request tracking.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (grant) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.fetch_rvalid_i)  state_d = ST_RUN;
        else if (bus.branch_i)   state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (bus.fetch_rvalid_i)  state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Halfword buffer, PC and fetch address.
  always_comb begin
    hw_d[0] = hw_q[0];
    hw_d[1] = hw_q[1];
    hw_d[2] = hw_q[2];
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    fa_d    = fa_q;
`ifdef FETCH_ALIGN_COMPRESSED_EN
    skip_d  = skip_q;
`endif

    if (grant) fa_d = fa_q + 32'd4;

    if (bus.branch_i) begin
      cnt_d = 2'd0;
      fa_d  = {bus.branch_addr_i[31:2], 2'b00};
`ifdef FETCH_ALIGN_COMPRESSED_EN
      pc_d   = {bus.branch_addr_i[31:1], 1'b0};
      skip_d = bus.branch_addr_i[1];
`else
      pc_d   = {bus.branch_addr_i[31:2], 2'b00};
`endif
    end else begin
      // Shift out the consumed instruction first; the response then lands behind what is left.
      if (consume) begin
        if (is_comp) begin
          hw_d[0] = hw_q[1];
          hw_d[1] = hw_q[2];
          pc_d    = pc_q + 32'd2;
        end else begin
          hw_d[0] = hw_q[2];
          pc_d    = pc_q + 32'd4;
        end
        cnt_d = cnt_left;
      end

      if (keep) begin
`ifdef FETCH_ALIGN_COMPRESSED_EN
        if (skip_q) begin
          unique case (cnt_left)
            2'd0:    hw_d[0] = rd_hi;
            2'd1:    hw_d[1] = rd_hi;
            default: hw_d[2] = rd_hi;
          endcase
          cnt_d  = cnt_left + 2'd1;
          skip_d = 1'b0;
        end else
`endif
        begin
          // cnt_left <= 1 is guaranteed here by the request rule.
          if (cnt_left == 2'd0) begin
            hw_d[0] = rd_lo;
            hw_d[1] = rd_hi;
          end else begin
            hw_d[1] = rd_lo;
            hw_d[2] = rd_hi;
          end
          cnt_d = cnt_left + 2'd2;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      hw_q[0] <= 16'h0000;
      hw_q[1] <= 16'h0000;
      hw_q[2] <= 16'h0000;
      cnt_q   <= 2'd0;
      pc_q    <= PC_RESET;
      fa_q    <= FA_RESET;
`ifdef FETCH_ALIGN_COMPRESSED_EN
      skip_q  <= RESET_PC[1];
`endif
    end else begin
      state_q <= state_d;
      hw_q[0] <= hw_d[0];
      hw_q[1] <= hw_d[1];
      hw_q[2] <= hw_d[2];
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      fa_q    <= fa_d;
`ifdef FETCH_ALIGN_COMPRESSED_EN
      skip_q  <= skip_d;
`endif
    end
  end

endmodule
